reg_rename_file: RTL
====================

Name: reg_rename_file

Overview:
- Architectural register file plus per-register rename tags, one stage downstream of the reorder buffer.
- Consumes ROB commit writes (value + ROB id) and dispatcher rename requests (rd -> new ROB id).
- Serves two combinational source-operand lookups to the dispatcher: value, or the ROB id that will produce it.
- Clears all rename tags on a mispredict flush.

Parameters:
- XLEN, 32, data width.
- REG_ADDR_W, 5, register index width (32 registers, x0 hardwired zero).
- ROB_ID_W, 5, ROB id width; valid ids 0..15.
- NON_DEP, 5'd16, tag value meaning "no pending producer".

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; when 0 all state holds.
- flush  in  1  mispredict; clears all tags.
- commit_en  in  1  ROB commit write valid.
- commit_rd  in  REG_ADDR_W  committed destination register.
- commit_val  in  XLEN  committed value.
- commit_id  in  ROB_ID_W  ROB id of committing entry.
- rename_en  in  1  dispatcher allocates producer for rename_rd.
- rename_rd  in  REG_ADDR_W  destination register being renamed.
- rename_id  in  ROB_ID_W  ROB id assigned.
- rs1, rs2  in  REG_ADDR_W  source lookups.
- Vj, Vk  out  XLEN  register value (valid when tag output is NON_DEP).
- Qj, Qk  out  ROB_ID_W  pending producer tag or NON_DEP.

Behaviour:
- Storage: val[32] XLEN, tag[32] ROB_ID_W.
- Reset (rst=0, async): all val=0, all tag=NON_DEP. Outputs are combinational, so during reset Vj/Vk=0 and Qj/Qk=NON_DEP.
- rdy=0: no state update; lookups still answer from current state.
- Commit (posedge, rdy=1, commit_en=1, commit_rd!=0):
  - val[commit_rd] <= commit_val.
  - If tag[commit_rd]==commit_id, then tag[commit_rd] <= NON_DEP.
  - Otherwise the tag is kept, because a younger producer exists.
- Rename (posedge, rdy=1, rename_en=1, rename_rd!=0, flush=0): tag[rename_rd] <= rename_id.
- Same register, same cycle, commit and rename: value is written and the tag becomes rename_id. Rename wins over tag clear.
- flush=1 (rdy=1):
  - All tags <= NON_DEP.
  - Rename is ignored.
  - Commit value write still happens; the ROB raises flush in the same cycle as the mispredicting commit.
- x0: writes and renames are discarded. Lookups of x0 always return Vx=0, Qx=NON_DEP.
- Lookup (combinational): Vj=val[rs1], Qj=tag[rs1]; same for rs2. No pipelining; zero latency.
- Lookups ignore a same-cycle rename. The dispatcher handles rd==rs of its own instruction.

Optional Feature:
- Macro REG_RENAME_FILE_BYPASS_EN. Defined: same-cycle commit forwarding to lookups. Applies when commit_en=1, rdy=1, commit_rd==rs1!=0 and tag[rs1]==commit_id:
  - Vj=commit_val, Qj=NON_DEP.
  - Same rule for rs2.
- Not defined: lookups reflect registered state only; the committed value appears the next cycle.

Decomposition:
- Shared package/define file holds:
  - XLEN, REG_ADDR_W, ROB_ID_W.
  - NON_DEP encoding, matching the ROB's non-dependent constant.
  - Register count.
- One natural sub-module: reg_rename_read_port. Takes one rs index plus state/commit inputs; produces V,Q including the x0 and bypass rules. Instantiated twice.

Test Plan:
- Reset then rs1=5, rs2=0 -> Vj=0, Qj=16, Vk=0, Qk=16.
- Rename x5->id 3; next cycle commit x5 val 0xDEADBEEF id 3 -> after commit Qj=16, Vj=0xDEADBEEF for rs1=5.
- Rename x7->id 2, then rename x7->id 9, then commit x7 id 2 val 0x11 -> Vk=0x11, Qk=9 (tag kept).
- Same cycle commit x4 id 6 (tag[4]=6) and rename x4->id 10 -> next cycle tag[4]=10, val[4]=commit value.
- Tags on x1..x31 set; flush with commit x8 val 0x55 -> all Q=16, val[8]=0x55, concurrent rename ignored.
- Bypass: tag[9]=1, commit x9 id 1 val 0x77, rs1=9 same cycle -> defined: Vj=0x77, Qj=16; undefined: Qj=1 until next edge.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// Shared widths and encodings for the architectural register file and its rename tags.
package reg_rename_file_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ROB_ID_W   = 5;
  localparam int unsigned NUM_REGS   = 32;

  // Must match the ROB's "no pending producer" encoding; real ROB ids are 0..15.
  localparam logic [ROB_ID_W-1:0] NON_DEP = ROB_ID_W'(16);

endpackage

// File: rtl/reg_rename_read_port.sv
// One source-operand lookup: value plus pending-producer tag, with x0 forcing.
// Optional same-cycle commit forwarding when REG_RENAME_FILE_BYPASS_EN is defined.
module reg_rename_read_port
  import reg_rename_file_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [XLEN-1:0]       vals [NUM_REGS],
  input  logic [ROB_ID_W-1:0]   tags [NUM_REGS],
  input  logic                  rdy,
  input  logic                  commit_en,
  input  logic [REG_ADDR_W-1:0] commit_rd,
  input  logic [XLEN-1:0]       commit_val,
  input  logic [ROB_ID_W-1:0]   commit_id,
  output logic [XLEN-1:0]       v,
  output logic [ROB_ID_W-1:0]   q
);

`ifndef REG_RENAME_FILE_BYPASS_EN
  logic unused_commit;
  assign unused_commit = ^{rdy, commit_en, commit_rd, commit_val, commit_id};
`endif

  always_comb begin
    v = vals[rs];
    q = tags[rs];
`ifdef REG_RENAME_FILE_BYPASS_EN
    // Forward only a commit from the producer this register is still waiting on.
    if (rdy && commit_en && (rs == commit_rd) && (tags[rs] == commit_id)) begin
      v = commit_val;
      q = NON_DEP;
    end
`endif
    if (rs == '0) begin
      v = '0;
      q = NON_DEP;
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags and two lookup ports.
// Define REG_RENAME_FILE_BYPASS_EN to forward same-cycle commits to the lookups.
module reg_rename_file
  import reg_rename_file_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  commit_en,
  input  logic [REG_ADDR_W-1:0] commit_rd,
  input  logic [XLEN-1:0]       commit_val,
  input  logic [ROB_ID_W-1:0]   commit_id,
  input  logic                  rename_en,
  input  logic [REG_ADDR_W-1:0] rename_rd,
  input  logic [ROB_ID_W-1:0]   rename_id,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]       Vj,
  output logic [XLEN-1:0]       Vk,
  output logic [ROB_ID_W-1:0]   Qj,
  output logic [ROB_ID_W-1:0]   Qk
);

  logic [XLEN-1:0]     vals [NUM_REGS];
  logic [ROB_ID_W-1:0] tags [NUM_REGS];

  // Later assignments win: rename overrides the commit's tag clear, flush overrides both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        vals[i] <= '0;
        tags[i] <= NON_DEP;
      end
    end else if (rdy) begin
      if (commit_en && (commit_rd != '0)) begin
        vals[commit_rd] <= commit_val;
        if (tags[commit_rd] == commit_id) tags[commit_rd] <= NON_DEP;
      end
      if (flush) begin
        for (int i = 0; i < NUM_REGS; i++) tags[i] <= NON_DEP;
      end else if (rename_en && (rename_rd != '0)) begin
        tags[rename_rd] <= rename_id;
      end
    end
  end

  reg_rename_read_port u_port_j (
    .rs(rs1), .vals(vals), .tags(tags), .rdy(rdy),
    .commit_en(commit_en), .commit_rd(commit_rd),
    .commit_val(commit_val), .commit_id(commit_id),
    .v(Vj), .q(Qj)
  );

  reg_rename_read_port u_port_k (
    .rs(rs2), .vals(vals), .tags(tags), .rdy(rdy),
    .commit_en(commit_en), .commit_rd(commit_rd),
    .commit_val(commit_val), .commit_id(commit_id),
    .v(Vk), .q(Qk)
  );

endmodule
